// File: rtl/mm_pkg.sv
// Shared types, constants and helpers for the mastermind feedback scorer.
package mm_pkg;

  localparam int COLOR_W    = 3;
  localparam int NUM_PEGS   = 4;
  localparam int NUM_COLORS = 8;

  // Default LFSR start value; must never be zero or the LFSR locks up.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef logic [COLOR_W-1:0] color_t;
  typedef color_t [NUM_PEGS-1:0] code_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXACT   = 2'd1,
    S_PARTIAL = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Smaller of two histogram entries: pegs of one colour that pair up.
  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] m;
    if (a < b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

endpackage

// File: rtl/feedback_scorer_if.sv
// Guess/score bundle between the guess-history stage and the feedback scorer.
interface feedback_scorer_if;
  import mm_pkg::*;

  logic        new_game;
  logic        score_start;
  color_t      guess3;
  color_t      guess2;
  color_t      guess1;
  color_t      guess0;
  logic        last_turn;
  logic        dbg_load;
  logic [11:0] dbg_secret;

  logic [2:0]  exact_count;
  logic [2:0]  partial_count;
  logic        score_valid;
  logic        busy;
  logic        win;
  logic        lose;
  color_t      reveal3;
  color_t      reveal2;
  color_t      reveal1;
  color_t      reveal0;

  // Upstream side: issues guesses and game control, receives feedback.
  modport master (
    output new_game, score_start, guess3, guess2, guess1, guess0, last_turn,
           dbg_load, dbg_secret,
    input  exact_count, partial_count, score_valid, busy, win, lose,
           reveal3, reveal2, reveal1, reveal0
  );

  // Scorer side.
  modport slave (
    input  new_game, score_start, guess3, guess2, guess1, guess0, last_turn,
           dbg_load, dbg_secret,
    output exact_count, partial_count, score_valid, busy, win, lose,
           reveal3, reveal2, reveal1, reveal0
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
module lfsr16
  import mm_pkg::*;
#(
  parameter logic [15:0] SEED = mm_pkg::LFSR_SEED
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = r_q[0] ^ r_q[2] ^ r_q[3] ^ r_q[5];
  assign q    = r_q;

  // Advance one step per cycle; reload the seed on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= SEED;
    end else begin
      r_q <= {w_fb, r_q[15:1]};
    end
  end

endmodule

// File: rtl/feedback_scorer.sv
// Scores a committed guess against the hidden secret: exact pass over the
// four slots, then a partial pass over the eight colour histograms.
module feedback_scorer #(
  parameter logic [15:0] LFSR_SEED = mm_pkg::LFSR_SEED
) (
  input  logic                clk,
  input  logic                reset,
  feedback_scorer_if.slave    bus
);
  import mm_pkg::*;

  logic [15:0] w_lfsr;
  logic [3:0]  w_lfsr_unused;

  state_t      r_state;
  logic [2:0]  r_idx;
  code_t       r_guess;
  code_t       r_secret;
  logic        r_last;
  logic [2:0]  r_exact;
  logic [2:0]  r_partial;
  logic [2:0]  r_ghist [NUM_COLORS];
  logic [2:0]  r_shist [NUM_COLORS];

  logic [2:0]  r_exact_out;
  logic [2:0]  r_partial_out;
  logic        r_valid;
  logic        r_busy;
  logic        r_win;
  logic        r_lose;
  code_t       r_reveal;

  color_t      w_g_col;
  color_t      w_s_col;
  logic        w_start_ok;
  code_t       w_secret_nxt;
  logic        w_win_nxt;
  logic        w_lose_nxt;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (w_lfsr)
  );

  // Only the low 12 bits form a secret; the rest just keeps the sequence long.
  assign w_lfsr_unused = w_lfsr[15:12];

  assign bus.exact_count   = r_exact_out;
  assign bus.partial_count = r_partial_out;
  assign bus.score_valid   = r_valid;
  assign bus.busy          = r_busy;
  assign bus.win           = r_win;
  assign bus.lose          = r_lose;
  assign bus.reveal3       = r_reveal[3];
  assign bus.reveal2       = r_reveal[2];
  assign bus.reveal1       = r_reveal[1];
  assign bus.reveal0       = r_reveal[0];

  // Next secret / flag values, shared by the flag registers and the reveal mask.
  always_comb begin
    w_g_col      = r_guess[r_idx[1:0]];
    w_s_col      = r_secret[r_idx[1:0]];
    // The busy term also blocks the single IDLE cycle right after DONE.
    w_start_ok   = bus.score_start && !r_win && !r_lose && !bus.new_game && !r_busy;
    w_secret_nxt = r_secret;
    w_win_nxt    = r_win;
    w_lose_nxt   = r_lose;
    if (bus.new_game) begin
      w_secret_nxt = code_t'(w_lfsr[11:0]);
      w_win_nxt    = 1'b0;
      w_lose_nxt   = 1'b0;
    end else begin
      if ((r_state == S_IDLE) && bus.dbg_load) begin
        w_secret_nxt = code_t'(bus.dbg_secret);
      end else begin
        w_secret_nxt = r_secret;
      end
      if (r_state == S_DONE) begin
        if (r_exact == 3'd4) begin
          w_win_nxt = 1'b1;
        end else if (r_last) begin
          w_lose_nxt = 1'b1;
        end else begin
          w_win_nxt  = r_win;
        end
      end else begin
        w_win_nxt = r_win;
      end
    end
  end

  // Scoring FSM with its histograms, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= 3'd0;
      r_guess       <= code_t'(12'd0);
      r_secret      <= code_t'(LFSR_SEED[11:0]);
      r_last        <= 1'b0;
      r_exact       <= 3'd0;
      r_partial     <= 3'd0;
      r_exact_out   <= 3'd0;
      r_partial_out <= 3'd0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
      r_win         <= 1'b0;
      r_lose        <= 1'b0;
      r_reveal      <= code_t'(12'd0);
      for (int i = 0; i < NUM_COLORS; i++) begin
        r_ghist[i] <= 3'd0;
        r_shist[i] <= 3'd0;
      end
    end else begin
      r_secret <= w_secret_nxt;
      r_win    <= w_win_nxt;
      r_lose   <= w_lose_nxt;
      r_reveal <= (w_win_nxt || w_lose_nxt) ? w_secret_nxt : code_t'(12'd0);
      if (bus.new_game) begin
        // Abort: the in-flight score is dropped and visible counts cleared.
        r_state       <= S_IDLE;
        r_idx         <= 3'd0;
        r_exact       <= 3'd0;
        r_partial     <= 3'd0;
        r_exact_out   <= 3'd0;
        r_partial_out <= 3'd0;
        r_valid       <= 1'b0;
        r_busy        <= 1'b0;
      end else begin
        r_valid <= 1'b0;
        r_busy  <= (r_state != S_IDLE);
        case (r_state)
          S_IDLE: begin
            if (w_start_ok) begin
              r_guess   <= {bus.guess3, bus.guess2, bus.guess1, bus.guess0};
              r_last    <= bus.last_turn;
              r_exact   <= 3'd0;
              r_partial <= 3'd0;
              r_idx     <= 3'd0;
              for (int i = 0; i < NUM_COLORS; i++) begin
                r_ghist[i] <= 3'd0;
                r_shist[i] <= 3'd0;
              end
              r_state   <= S_EXACT;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_EXACT: begin
            // Matched slots count as exact; unmatched pegs feed the histograms.
            if (w_g_col == w_s_col) begin
              r_exact <= r_exact + 3'd1;
            end else begin
              r_ghist[w_g_col] <= r_ghist[w_g_col] + 3'd1;
              r_shist[w_s_col] <= r_shist[w_s_col] + 3'd1;
            end
            if (r_idx == 3'd3) begin
              r_idx   <= 3'd0;
              r_state <= S_PARTIAL;
            end else begin
              r_idx   <= r_idx + 3'd1;
            end
          end
          S_PARTIAL: begin
            r_partial <= r_partial + min3(r_ghist[r_idx], r_shist[r_idx]);
            if (r_idx == 3'd7) begin
              r_idx   <= 3'd0;
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 3'd1;
            end
          end
          S_DONE: begin
            r_valid       <= 1'b1;
            r_exact_out   <= r_exact;
            r_partial_out <= r_partial;
            r_state       <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_feedback_scorer.sv
// Directed bench for feedback_scorer with hand-computed expected scores.
module tb_feedback_scorer;
  import mm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat;
  int   pulses;
  logic seen_busy;
  logic [2:0] got_exact;
  logic [2:0] got_partial;

  always #5 clk = ~clk;

  feedback_scorer_if bus_if ();

  feedback_scorer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Every comparison funnels through here.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] code(input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] c, input logic [2:0] d);
    return {a, b, c, d};
  endfunction

  function automatic logic [11:0] reveal();
    return {bus_if.reveal3, bus_if.reveal2, bus_if.reveal1, bus_if.reveal0};
  endfunction

  task automatic set_guess(input logic [11:0] g);
    bus_if.guess3 = g[11:9];
    bus_if.guess2 = g[8:6];
    bus_if.guess1 = g[5:3];
    bus_if.guess0 = g[2:0];
  endtask

  task automatic pulse_new_game();
    bus_if.new_game = 1'b1;
    tick();
    bus_if.new_game = 1'b0;
  endtask

  task automatic load(input logic [11:0] s);
    bus_if.dbg_load   = 1'b1;
    bus_if.dbg_secret = s;
    tick();
    bus_if.dbg_load   = 1'b0;
  endtask

  // Start a score and wait (bounded) for score_valid; lat = edges after start.
  task automatic score(input logic [11:0] g, input logic lt, output int l);
    set_guess(g);
    bus_if.last_turn   = lt;
    bus_if.score_start = 1'b1;
    tick();
    bus_if.score_start = 1'b0;
    bus_if.last_turn   = 1'b0;
    l = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (bus_if.score_valid) begin
        l = n;
        break;
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus_if.new_game    = 1'b0;
    bus_if.score_start = 1'b0;
    bus_if.last_turn   = 1'b0;
    bus_if.dbg_load    = 1'b0;
    bus_if.dbg_secret  = 12'd0;
    set_guess(12'd0);
    repeat (3) tick();
    reset = 1'b0;

    // 1. Reset state and LFSR stepping.
    check("rst_exact",   32'(bus_if.exact_count),   32'd0);
    check("rst_partial", 32'(bus_if.partial_count), 32'd0);
    check("rst_valid",   32'(bus_if.score_valid),   32'd0);
    check("rst_busy",    32'(bus_if.busy),          32'd0);
    check("rst_flags",   32'({bus_if.win, bus_if.lose}), 32'd0);
    check("rst_reveal",  32'(reveal()),             32'd0);
    check("rst_lfsr",    32'(dut.w_lfsr),           32'h0000ACE1);
    tick();
    check("lfsr_step1",  32'(dut.w_lfsr),           32'h00005670);

    // 2. Exact win with 13-edge latency.
    load(code(3'd1, 3'd2, 3'd3, 3'd4));
    score(code(3'd1, 3'd2, 3'd3, 3'd4), 1'b0, lat);
    check("win_latency", 32'(lat), 32'd13);
    check("win_exact",   32'(bus_if.exact_count),   32'd4);
    check("win_partial", 32'(bus_if.partial_count), 32'd0);
    check("win_flag",    32'(bus_if.win),           32'd1);
    check("win_lose",    32'(bus_if.lose),          32'd0);
    check("win_reveal",  32'(reveal()),             32'(code(3'd1, 3'd2, 3'd3, 3'd4)));
    tick();
    check("win_valid_1cyc", 32'(bus_if.score_valid), 32'd0);
    check("win_sticky",  32'(bus_if.win),           32'd1);

    // 3. All pegs present, none in place.
    pulse_new_game();
    check("ng_win_clr",  32'(bus_if.win),           32'd0);
    check("ng_exact_clr",32'(bus_if.exact_count),   32'd0);
    check("ng_reveal",   32'(reveal()),             32'd0);
    load(code(3'd4, 3'd3, 3'd2, 3'd1));
    score(code(3'd1, 3'd2, 3'd3, 3'd4), 1'b0, lat);
    check("rev_latency", 32'(lat), 32'd13);
    check("rev_exact",   32'(bus_if.exact_count),   32'd0);
    check("rev_partial", 32'(bus_if.partial_count), 32'd4);
    check("rev_flags",   32'({bus_if.win, bus_if.lose}), 32'd0);
    check("rev_reveal",  32'(reveal()),             32'd0);

    // 4. Duplicate colours.
    load(code(3'd1, 3'd1, 3'd2, 3'd2));
    score(code(3'd1, 3'd2, 3'd1, 3'd1), 1'b0, lat);
    check("dup1_exact",   32'(bus_if.exact_count),   32'd1);
    check("dup1_partial", 32'(bus_if.partial_count), 32'd2);
    load(code(3'd0, 3'd0, 3'd0, 3'd0));
    score(code(3'd0, 3'd7, 3'd7, 3'd7), 1'b0, lat);
    check("dup2_exact",   32'(bus_if.exact_count),   32'd1);
    check("dup2_partial", 32'(bus_if.partial_count), 32'd0);

    // 6a. new_game five edges into a score aborts it.
    load(code(3'd3, 3'd3, 3'd3, 3'd3));
    set_guess(code(3'd3, 3'd3, 3'd3, 3'd3));
    bus_if.score_start = 1'b1;
    tick();
    bus_if.score_start = 1'b0;
    repeat (3) tick();
    check("abort_busy_before", 32'(bus_if.busy), 32'd1);
    tick();
    pulse_new_game();
    check("abort_busy",    32'(bus_if.busy),          32'd0);
    check("abort_exact",   32'(bus_if.exact_count),   32'd0);
    check("abort_partial", 32'(bus_if.partial_count), 32'd0);
    check("abort_flags",   32'({bus_if.win, bus_if.lose}), 32'd0);
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (bus_if.score_valid) pulses++;
    end
    check("abort_no_valid", 32'(pulses), 32'd0);

    // 6b. A second start while busy is ignored.
    load(code(3'd1, 3'd2, 3'd3, 3'd4));
    set_guess(code(3'd4, 3'd3, 3'd2, 3'd1));
    bus_if.score_start = 1'b1;
    tick();
    bus_if.score_start = 1'b0;
    repeat (2) tick();
    set_guess(code(3'd1, 3'd2, 3'd3, 3'd4));
    bus_if.score_start = 1'b1;
    tick();
    bus_if.score_start = 1'b0;
    pulses      = 0;
    got_exact   = 3'd7;
    got_partial = 3'd7;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (bus_if.score_valid) begin
        pulses++;
        got_exact   = bus_if.exact_count;
        got_partial = bus_if.partial_count;
      end
    end
    check("busy_start_pulses",  32'(pulses),      32'd1);
    check("busy_start_exact",   32'(got_exact),   32'd0);
    check("busy_start_partial", 32'(got_partial), 32'd4);
    check("busy_start_win",     32'(bus_if.win),  32'd0);

    // 5. Final turn miss sets lose; later starts are ignored.
    load(code(3'd5, 3'd5, 3'd5, 3'd5));
    score(code(3'd6, 3'd6, 3'd6, 3'd6), 1'b1, lat);
    check("lose_latency", 32'(lat), 32'd13);
    check("lose_exact",   32'(bus_if.exact_count),   32'd0);
    check("lose_partial", 32'(bus_if.partial_count), 32'd0);
    check("lose_flag",    32'(bus_if.lose),          32'd1);
    check("lose_win",     32'(bus_if.win),           32'd0);
    check("lose_reveal",  32'(reveal()),             32'(code(3'd5, 3'd5, 3'd5, 3'd5)));
    tick();
    bus_if.score_start = 1'b1;
    tick();
    bus_if.score_start = 1'b0;
    seen_busy = 1'b0;
    pulses    = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (bus_if.busy) seen_busy = 1'b1;
      if (bus_if.score_valid) pulses++;
    end
    check("over_busy",   32'(seen_busy),   32'd0);
    check("over_valid",  32'(pulses),      32'd0);
    check("over_sticky", 32'(bus_if.lose), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
